ram_bank_sweep: RTL and testbench

- Parametrised successor to the fixed 64-word, 16-bit banked RAM.
- Word width, address width and bank split are configurable.
- Adds a registered read port with a valid flag, and a hardware zero-fill sweep that runs after reset and on request.
- Serves as general data memory behind the CPU datapath; the memory is known-zero before first use.

---
 rtl/ram_bank_sweep.sv | 121 ++++++++++++
 tb/tb_ram_bank_sweep.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_sweep.sv
// Banked single-port data RAM with a registered read port and a hardware zero-fill sweep.
// Contents are swept to zero after reset release and again whenever clear is requested.
module ram_bank_sweep #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned ADDR_BITS = 6,
   parameter int unsigned BANK_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in,
   input  logic [ADDR_BITS-1:0] address,
   input  logic                 load,
   input  logic                 rd_en,
   input  logic                 clear,
   output logic [WIDTH-1:0]     out,
   output logic                 out_valid,
   output logic                 busy
);

   localparam int unsigned WORD_BITS  = ADDR_BITS - BANK_BITS;
   localparam int unsigned NUM_BANKS  = 2 ** BANK_BITS;
   localparam int unsigned BANK_DEPTH = 2 ** WORD_BITS;

   // One spare bit on the counter so the terminal compare can never alias.
   localparam logic [ADDR_BITS:0] LAST_WORD = {1'b0, {ADDR_BITS{1'b1}}};

   typedef enum logic {
      StSweep,
      StIdle
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_BITS:0]   cnt_q, cnt_d;

   logic                 sweeping;
   logic                 rd_fire;
   logic                 wr_en;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic [BANK_BITS-1:0] wr_bank;
   logic [WORD_BITS-1:0] wr_word;
   logic [BANK_BITS-1:0] rd_bank;
   logic [WORD_BITS-1:0] rd_word;
   logic [WIDTH-1:0]     bank_rdata [NUM_BANKS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StSweep;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StSweep: begin
            cnt_d = cnt_q + (ADDR_BITS + 1)'(1);
            if (cnt_q == LAST_WORD) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (clear) begin
               state_d = StSweep;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StSweep;
            cnt_d   = '0;
         end
      endcase
   end

   assign sweeping = (state_q == StSweep);
   assign busy     = sweeping;
   assign rd_fire  = !sweeping && rd_en;

   // The sweep owns the single write port; a user load coinciding with clear is dropped.
   assign wr_en   = sweeping || (load && !clear);
   assign wr_addr = sweeping ? cnt_q[ADDR_BITS-1:0] : address;
   assign wr_data = sweeping ? '0 : in;

   assign wr_bank = wr_addr[ADDR_BITS-1 -: BANK_BITS];
   assign wr_word = wr_addr[WORD_BITS-1:0];
   assign rd_bank = address[ADDR_BITS-1 -: BANK_BITS];
   assign rd_word = address[WORD_BITS-1:0];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [WIDTH-1:0] mem [BANK_DEPTH];
      logic             we;

      assign we = wr_en && (wr_bank == BANK_BITS'(b));

      always_ff @(posedge clk) begin
         if (we) begin
            mem[wr_word] <= wr_data;
         end
      end

      // Asynchronous array read sampled into out gives read-before-write on collisions.
      assign bank_rdata[b] = mem[rd_word];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= rd_fire;
         if (rd_fire) begin
            out <= bank_rdata[rd_bank];
         end
      end
   end

endmodule

// File: tb/tb_ram_bank_sweep.sv
// Scoreboard bench for ram_bank_sweep: default geometry plus a WIDTH=8/ADDR_BITS=4/BANK_BITS=2 copy.
module tb_ram_bank_sweep;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] in = '0;
   logic [5:0]  address = '0;
   logic        load = 1'b0;
   logic        rd_en = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] out;
   logic        out_valid;
   logic        busy;

   logic        v_rst_n = 1'b1;
   logic [7:0]  v_in = '0;
   logic [3:0]  v_address = '0;
   logic        v_load = 1'b0;
   logic        v_rd_en = 1'b0;
   logic        v_clear = 1'b0;
   logic [7:0]  v_out;
   logic        v_out_valid;
   logic        v_busy;

   int          checks_total = 0;
   int          checks_passed = 0;
   logic [15:0] exp_q [$];
   logic [7:0]  v_exp_q [$];

   always #5 clk = ~clk;

   ram_bank_sweep dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .address   (address),
      .load      (load),
      .rd_en     (rd_en),
      .clear     (clear),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   ram_bank_sweep #(
      .WIDTH     (8),
      .ADDR_BITS (4),
      .BANK_BITS (2)
   ) dut_small (
      .clk       (clk),
      .rst_n     (v_rst_n),
      .in        (v_in),
      .address   (v_address),
      .load      (v_load),
      .rd_en     (v_rd_en),
      .clear     (v_clear),
      .out       (v_out),
      .out_valid (v_out_valid),
      .busy      (v_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitors: every out_valid must match the oldest outstanding expected read.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) check("spurious out_valid", 32'(out_valid), 32'd0);
         else check("read data", 32'(out), 32'(exp_q.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (v_out_valid === 1'b1) begin
         if (v_exp_q.size() == 0) check("small spurious out_valid", 32'(v_out_valid), 32'd0);
         else check("small read data", 32'(v_out), 32'(v_exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] e);
      address = a;
      rd_en   = 1'b1;
      exp_q.push_back(e);
      tick();
      rd_en   = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      #1;
      rst_n   = 1'b0;
      v_rst_n = 1'b0;
      #2;
      check("reset out", 32'(out), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd1);

      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("initial sweep length", n, 64);

      for (int a = 0; a < 64; a++) rd(6'(a), 16'h0000);
      tick();

      // Bank isolation: 36 shares the bank with 37, 45 is the same word in another bank.
      wr(6'd37, 16'hBEEF);
      rd(6'd37, 16'hBEEF);
      rd(6'd36, 16'h0000);
      rd(6'd45, 16'h0000);
      tick();

      wr(6'd5, 16'hAAAA);
      address = 6'd5;
      in      = 16'h1234;
      load    = 1'b1;
      rd_en   = 1'b1;
      exp_q.push_back(16'hAAAA);
      tick();
      load    = 1'b0;
      rd_en   = 1'b0;
      rd(6'd5, 16'h1234);
      tick();

      wr(6'd0, 16'hFFFF);
      wr(6'd7, 16'hFFFF);
      wr(6'd8, 16'hFFFF);
      wr(6'd63, 16'hFFFF);
      // Clear with a coincident read (serviced) and load (dropped).
      clear   = 1'b1;
      address = 6'd37;
      rd_en   = 1'b1;
      load    = 1'b1;
      in      = 16'h9999;
      exp_q.push_back(16'hBEEF);
      tick();
      clear   = 1'b0;
      check("busy after clear", 32'(busy), 32'd1);
      address = 6'd3;
      in      = 16'h5555;
      count_busy(n);
      check("clear sweep length", n, 64);
      load    = 1'b0;
      rd_en   = 1'b0;
      rd(6'd0, 16'h0000);
      rd(6'd7, 16'h0000);
      rd(6'd8, 16'h0000);
      rd(6'd63, 16'h0000);
      rd(6'd3, 16'h0000);
      rd(6'd37, 16'h0000);
      tick();

      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (29) tick();
      rst_n = 1'b0;
      #1;
      check("mid-sweep reset out_valid", 32'(out_valid), 32'd0);
      check("mid-sweep reset busy", 32'(busy), 32'd1);
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("sweep length after mid-sweep reset", n, 64);

      wr(6'd12, 16'h3C3C);
      address = 6'd12;
      rd_en   = 1'b1;
      tick();
      rd_en   = 1'b0;
      check("pre-reset out_valid", 32'(out_valid), 32'd1);
      check("pre-reset out", 32'(out), 32'h3C3C);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid-read reset out_valid", 32'(out_valid), 32'd0);
      check("mid-read reset out", 32'(out), 32'd0);
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("sweep length after mid-read reset", n, 64);

      check("small reset busy", 32'(v_busy), 32'd1);
      v_rst_n = 1'b1;
      n = 0;
      while (v_busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("small sweep length", n, 16);
      v_address = 4'd15;
      v_in      = 8'h5A;
      v_load    = 1'b1;
      tick();
      v_address = 4'd0;
      v_in      = 8'hA5;
      tick();
      v_load    = 1'b0;
      v_rd_en   = 1'b1;
      v_address = 4'd15;
      v_exp_q.push_back(8'h5A);
      tick();
      v_address = 4'd0;
      v_exp_q.push_back(8'hA5);
      tick();
      v_address = 4'd14;
      v_exp_q.push_back(8'h00);
      tick();
      v_rd_en   = 1'b0;

      repeat (3) tick();
      check("outstanding reads", exp_q.size(), 0);
      check("small outstanding reads", v_exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
